// File: rtl/fpu_result_queue.sv
// rtl/fpu_result_queue.sv - FIFO between FPU result producers and FP register-file writeback.
// Optional combinational empty-queue bypass is enabled by defining FPU_RESULT_QUEUE_BYPASS_EN.
module fpu_result_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_data,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic [TAG_W-1:0]         out_tag,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]      data_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem  [DEPTH];

   logic [PW-1:0]    wr_ptr, rd_ptr, wr_next, rd_next;
   logic [CW-1:0]    count_q, count_next;
   logic             ov_q;
   logic [31:0]      od_q, head_data;
   logic [TAG_W-1:0] ot_q, head_tag;
   logic [31:0]      san_data;
   logic             push, pop, bypass_take;

   // Zero exponent covers both denormals and signed zero.
   assign san_data = (in_data[30:23] == 8'd0) ? {in_data[31], 31'd0} : in_data;

   assign in_ready = (count_q != CW'(DEPTH));
   assign count    = count_q;

`ifdef FPU_RESULT_QUEUE_BYPASS_EN
   logic bypass_show;
   assign bypass_show = (count_q == '0) && in_valid && !flush;
   assign bypass_take = bypass_show && out_ready;
   assign out_valid   = bypass_show | ov_q;
   assign out_data    = bypass_show ? san_data : od_q;
   assign out_tag     = bypass_show ? in_tag : ot_q;
`else
   assign bypass_take = 1'b0;
   assign out_valid   = ov_q;
   assign out_data    = od_q;
   assign out_tag     = ot_q;
`endif

   assign push = in_valid && in_ready && !bypass_take;
   assign pop  = ov_q && out_ready;

   always_comb begin
      wr_next    = wr_ptr;
      rd_next    = rd_ptr;
      count_next = count_q;
      head_data  = '0;
      head_tag   = '0;
      if (flush) begin
         wr_next    = '0;
         rd_next    = '0;
         count_next = '0;
      end else begin
         if (push) wr_next = wr_ptr + 1'b1;
         if (pop)  rd_next = rd_ptr + 1'b1;
         if (push && !pop)      count_next = count_q + 1'b1;
         else if (pop && !push) count_next = count_q - 1'b1;
      end
      // The new head may be the slot being written this very edge.
      if (push && !flush && (wr_ptr == rd_next)) begin
         head_data = san_data;
         head_tag  = in_tag;
      end else begin
         head_data = data_mem[rd_next];
         head_tag  = tag_mem[rd_next];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         ot_q    <= '0;
      end else begin
         wr_ptr  <= wr_next;
         rd_ptr  <= rd_next;
         count_q <= count_next;
         ov_q    <= (count_next != '0);
         od_q    <= head_data;
         ot_q    <= head_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         data_mem[wr_ptr] <= san_data;
         tag_mem[wr_ptr]  <= in_tag;
      end
   end

endmodule

// File: tb/tb_fpu_result_queue.sv
// tb/tb_fpu_result_queue.sv - directed self-checking bench for fpu_result_queue.
module tb_fpu_result_queue;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] in_data, out_data;
   logic [4:0]  in_tag, out_tag;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;

   fpu_result_queue #(.DEPTH(4), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] d, input logic [4:0] t);
      in_valid = 1'b1;
      in_data  = d;
      in_tag   = t;
      step();
      in_valid = 1'b0;
   endtask

   logic [31:0] fill_d [4];
   logic [31:0] dn_in  [3];
   logic [31:0] dn_exp [3];

   initial begin
      fill_d[0] = 32'h4000_0000; fill_d[1] = 32'h4040_0000;
      fill_d[2] = 32'h4080_0000; fill_d[3] = 32'hBF80_0000;
      dn_in[0]  = 32'h0000_0001; dn_in[1]  = 32'h8040_0000; dn_in[2]  = 32'h7F80_0000;
      dn_exp[0] = 32'h0000_0000; dn_exp[1] = 32'h8000_0000; dn_exp[2] = 32'h7F80_0000;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_tag = '0;
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_out_data", out_data, 0);
      step(); step();
      rst = 1'b0;
      step();

      // single push, 1-cycle latency
      push_one(32'h3F80_0000, 5'd3);
      check("single_valid", out_valid, 1);
      check("single_data", out_data, 32'h3F80_0000);
      check("single_tag", out_tag, 3);
      check("single_count", count, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("single_pop_count", count, 0);
      check("single_pop_valid", out_valid, 0);

      // fill and backpressure
      for (int i = 0; i < 4; i++) push_one(fill_d[i], 5'(i + 1));
      check("full_count", count, 4);
      check("full_in_ready", in_ready, 0);
      push_one(32'h1234_5678, 5'd9);
      check("held_count", count, 4);
      check("held_head", out_data, fill_d[0]);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("fill_pop_data", out_data, fill_d[i]);
         check("fill_pop_tag", out_tag, 32'(i + 1));
         step();
         if (i == 0) check("in_ready_after_pop", in_ready, 1);
      end
      out_ready = 1'b0;
      check("drained_valid", out_valid, 0);
      check("drained_count", count, 0);

      // simultaneous push/pop at count=2, pointers wrap
      push_one(32'h4100_0000, 5'd0);
      push_one(32'h4100_0001, 5'd1);
      check("pp_start_count", count, 2);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_data = 32'h4100_0002 + 32'(k);
         in_tag  = 5'(k + 2);
         check("pp_data", out_data, 32'h4100_0000 + 32'(k));
         check("pp_tag", out_tag, 32'(k));
         step();
         check("pp_count", count, 2);
      end
      in_valid = 1'b0;
      for (int k = 10; k < 12; k++) begin
         check("pp_drain_data", out_data, 32'h4100_0000 + 32'(k));
         check("pp_drain_tag", out_tag, 32'(k));
         step();
      end
      out_ready = 1'b0;
      check("pp_empty", count, 0);

      // denormal and zero sanitizing
      for (int i = 0; i < 3; i++) push_one(dn_in[i], 5'(20 + i));
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("dn_data", out_data, dn_exp[i]);
         check("dn_tag", out_tag, 32'(20 + i));
         step();
      end
      out_ready = 1'b0;

      // flush overrides concurrent push
      for (int i = 0; i < 3; i++) push_one(32'h4000_0000, 5'(i));
      check("pre_flush_count", count, 3);
      flush = 1'b1; in_valid = 1'b1; in_data = 32'h4228_0000; in_tag = 5'd11;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_count", count, 0);
      check("flush_valid", out_valid, 0);
      check("flush_in_ready", in_ready, 1);
      push_one(32'h40A0_0000, 5'd7);
      check("post_flush_valid", out_valid, 1);
      check("post_flush_data", out_data, 32'h40A0_0000);
      check("post_flush_tag", out_tag, 7);
      check("post_flush_count", count, 1);
      push_one(32'h40C0_0000, 5'd8);
      check("pre_rst_count", count, 2);

      // asynchronous reset mid-cycle
      #2 rst = 1'b1;
      #1;
      check("async_valid", out_valid, 0);
      check("async_count", count, 0);
      check("async_in_ready", in_ready, 1);
      #1 rst = 1'b0;
      step();
      check("after_rst_count", count, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
